imem_loader: RTL and testbench



---
 rtl/imem_loader.sv | 104 ++++++++++
 tb/tb_imem_loader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader
//   Boot-time program loader for the single-cycle core. Takes a byte stream
//   (valid/ready), reads a big-endian 32-bit word count N, then assembles N
//   big-endian instruction words and writes them to instruction memory at
//   word addresses 0..N-1. The core is held in reset until the last write
//   has landed, then released so it fetches from PC = 0.
//
// Ports
//   clk, reset      : clock, synchronous active-high reset
//   i_byte, i_valid : incoming stream byte and its valid
//   o_ready         : a byte is accepted on an edge with i_valid && o_ready
//   o_imem_we       : one-cycle write pulse per assembled word
//   o_imem_addr     : word address (byte address = addr << 2)
//   o_imem_wdata    : instruction word
//   o_cpu_reset     : core reset, high until the load completes
//   o_done          : load complete, core running
//   o_error         : header count exceeded memory capacity
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        i_byte,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic              o_cpu_reset,
  output logic              o_done,
  output logic              o_error
);

  localparam logic [2:0] S_HDR  = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_WR   = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  // Capacity in words; compared at 33 bits so 2^ADDR_W itself is legal.
  localparam logic [32:0]     CAP = 33'd1 << ADDR_W;
  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [2:0]      state;
  logic [1:0]      byte_cnt;
  logic [23:0]     hdr;      // first three header bytes; the 4th arrives live
  logic [31:0]     word;
  logic [ADDR_W:0] addr;     // one extra bit so a full load never aliases
  logic [ADDR_W:0] rem;      // words still to write
  logic [31:0]     n_next;
  logic            accept;

  assign accept = i_valid && o_ready;
  assign n_next = {hdr, i_byte};

  // Every output is decoded from state or taken straight from a register.
  assign o_ready      = (state == S_HDR) || (state == S_LOAD);
  assign o_imem_we    = (state == S_WR);
  assign o_imem_addr  = addr[ADDR_W-1:0];
  assign o_imem_wdata = word;
  assign o_cpu_reset  = (state != S_RUN);
  assign o_done       = (state == S_RUN);
  assign o_error      = (state == S_ERR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_HDR;
      byte_cnt <= '0;
      hdr      <= '0;
      word     <= '0;
      addr     <= '0;
      rem      <= '0;
    end else begin
      case (state)
        S_HDR: if (accept) begin
          hdr      <= {hdr[15:0], i_byte};
          byte_cnt <= byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            rem <= n_next[ADDR_W:0];
            if (n_next == 32'd0)              state <= S_RUN;
            else if ({1'b0, n_next} > CAP)    state <= S_ERR;
            else                              state <= S_LOAD;
          end
        end
        S_LOAD: if (accept) begin
          word     <= {word[23:0], i_byte};
          byte_cnt <= byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) state <= S_WR;
        end
        S_WR: begin
          // addr/word stay put during this cycle; they advance on its exit edge.
          addr <= addr + ONE;
          rem  <= rem - ONE;
          if (rem == ONE) state <= S_RUN;
          else            state <= S_LOAD;
        end
        S_RUN:   state <= S_RUN;
        S_ERR:   state <= S_ERR;
        default: state <= S_HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (ADDR_W = 8).
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  i_byte;
  logic        i_valid;
  logic        o_ready;
  logic        o_imem_we;
  logic [7:0]  o_imem_addr;
  logic [31:0] o_imem_wdata;
  logic        o_cpu_reset;
  logic        o_done;
  logic        o_error;

  int n_tests = 0;
  int n_fail  = 0;

  // write log filled by the monitor
  logic [7:0]  wr_addr [$];
  logic [31:0] wr_data [$];
  int          ready_viol = 0;
  int          rstw_viol  = 0;

  imem_loader #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .i_byte(i_byte), .i_valid(i_valid),
    .o_ready(o_ready), .o_imem_we(o_imem_we), .o_imem_addr(o_imem_addr),
    .o_imem_wdata(o_imem_wdata), .o_cpu_reset(o_cpu_reset),
    .o_done(o_done), .o_error(o_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_imem_we) begin
      wr_addr.push_back(o_imem_addr);
      wr_data.push_back(o_imem_wdata);
      if (o_ready)      ready_viol++;
      if (!o_cpu_reset) rstw_viol++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; i_valid = 1'b0; i_byte = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Present a byte after `gap` idle cycles and hold it until accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    @(negedge clk);
    if (gap > 0) begin
      i_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    i_valid = 1'b1; i_byte = b;
    while (!o_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("accept_timeout", 32'(t), 32'd0);
    @(posedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int i = 3; i >= 0; i--)
      send_byte(w[i*8 +: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  task automatic idle();
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  logic [31:0] burst_w [3];
  int base;

  initial begin
    reset = 1'b0; i_valid = 1'b0; i_byte = 8'h00;
    burst_w[0] = 32'h3C01_1234;
    burst_w[1] = 32'hAC22_0004;
    burst_w[2] = 32'h0800_0000;

    // reset values
    do_reset();
    chk("rst_ready",    32'(o_ready),      32'd1);
    chk("rst_cpu_reset",32'(o_cpu_reset),  32'd1);
    chk("rst_done",     32'(o_done),       32'd0);
    chk("rst_error",    32'(o_error),      32'd0);
    chk("rst_we",       32'(o_imem_we),    32'd0);
    chk("rst_addr",     32'(o_imem_addr),  32'd0);
    chk("rst_wdata",    o_imem_wdata,      32'd0);

    // two-word load, valid continuously high
    base = wr_addr.size();
    send_word(32'h0000_0002, 0);
    send_word(32'h2008_0005, 0);
    send_word(32'h0109_5020, 0);
    @(negedge clk);   // final WR cycle
    chk("two_last_wr_we",     32'(o_imem_we),   32'd1);
    chk("two_last_wr_ready",  32'(o_ready),     32'd0);
    chk("two_last_wr_cpurst", 32'(o_cpu_reset), 32'd1);
    @(negedge clk);   // first RUN cycle
    chk("two_run_cpurst", 32'(o_cpu_reset), 32'd0);
    chk("two_run_done",   32'(o_done),      32'd1);
    chk("two_nwr",  32'(wr_addr.size() - base), 32'd2);
    if (wr_addr.size() - base == 2) begin
      chk("two_a0", 32'(wr_addr[base]),   32'd0);
      chk("two_d0", wr_data[base],        32'h2008_0005);
      chk("two_a1", 32'(wr_addr[base+1]), 32'd1);
      chk("two_d1", wr_data[base+1],      32'h0109_5020);
    end
    // bytes after RUN are ignored
    i_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      i_byte = 8'(8'h55 + i);
      @(negedge clk);
    end
    i_valid = 1'b0;
    chk("two_post_nwr",  32'(wr_addr.size() - base), 32'd2);
    chk("two_post_done", 32'(o_done),  32'd1);
    chk("two_post_ready",32'(o_ready), 32'd0);

    // zero-length program
    do_reset();
    base = wr_addr.size();
    send_word(32'h0000_0000, 0);
    idle();
    chk("zero_done",   32'(o_done),      32'd1);
    chk("zero_cpurst", 32'(o_cpu_reset), 32'd0);
    repeat (3) @(negedge clk);
    chk("zero_nwr", 32'(wr_addr.size() - base), 32'd0);

    // overflow N = 257
    do_reset();
    base = wr_addr.size();
    send_word(32'h0000_0101, 0);
    idle();
    chk("ovf_error",  32'(o_error),     32'd1);
    chk("ovf_cpurst", 32'(o_cpu_reset), 32'd1);
    chk("ovf_ready",  32'(o_ready),     32'd0);
    chk("ovf_done",   32'(o_done),      32'd0);
    repeat (5) @(negedge clk);
    chk("ovf_nwr",    32'(wr_addr.size() - base), 32'd0);
    chk("ovf_hold",   32'(o_error),     32'd1);

    // full-capacity load N = 256
    do_reset();
    base = wr_addr.size();
    send_word(32'h0000_0100, 0);
    for (int i = 0; i < 256; i++) send_word(32'hC000_0000 | (32'(i) * 32'd7), 0);
    @(negedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    chk("full_nwr",  32'(wr_addr.size() - base), 32'd256);
    chk("full_done", 32'(o_done), 32'd1);
    if (wr_addr.size() - base == 256) begin
      chk("full_last_addr", 32'(wr_addr[base+255]), 32'h0000_00FF);
      for (int i = 0; i < 256; i++) begin
        chk("full_addr", 32'(wr_addr[base+i]), 32'(i));
        chk("full_data", wr_data[base+i], 32'hC000_0000 | (32'(i) * 32'd7));
      end
    end

    // bursty valid, 3 words
    do_reset();
    base = wr_addr.size();
    send_word(32'h0000_0003, 7);
    for (int i = 0; i < 3; i++) send_word(burst_w[i], 7);
    idle();
    @(negedge clk);
    chk("burst_nwr",  32'(wr_addr.size() - base), 32'd3);
    chk("burst_done", 32'(o_done), 32'd1);
    if (wr_addr.size() - base == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("burst_addr", 32'(wr_addr[base+i]), 32'(i));
        chk("burst_data", wr_data[base+i], burst_w[i]);
      end
    end

    // reset mid-load, then a fresh stream
    do_reset();
    send_word(32'h0000_0002, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    @(negedge clk);
    i_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("mid_cpurst", 32'(o_cpu_reset), 32'd1);
    chk("mid_ready",  32'(o_ready),     32'd1);
    chk("mid_done",   32'(o_done),      32'd0);
    chk("mid_we",     32'(o_imem_we),   32'd0);
    base = wr_addr.size();
    send_word(32'h0000_0001, 0);
    send_word(32'hAABB_CCDD, 0);
    idle();
    @(negedge clk);
    chk("mid_nwr",  32'(wr_addr.size() - base), 32'd1);
    if (wr_addr.size() - base == 1) begin
      chk("mid_a0", 32'(wr_addr[base]), 32'd0);
      chk("mid_d0", wr_data[base],      32'hAABB_CCDD);
    end
    chk("mid_fin_done", 32'(o_done), 32'd1);

    chk("ready_low_in_wr",  32'(ready_viol), 32'd0);
    chk("cpurst_high_in_wr",32'(rstw_viol),  32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
